// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
// Holds the FSM state encoding, the default lock limit and a wrap helper.
package bus_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam int MAX_BEATS_DEF = 4;
   localparam int SEL_W         = 2;

   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester-side bundle of the arbiter: requests, source words and grant/bus results.
// The master modport is the requester side; the slave modport is the arbiter.
interface bus_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int NDST = 4
);
   import bus_arbiter_pkg::*;

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       lock;
   logic [NREQ*W-1:0]     src_data;
   logic [NREQ*SEL_W-1:0] dst_sel;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [W-1:0]          bus;
   logic [NDST-1:0]       dst_write;
   logic                  busy;

   modport master (
      output req, lock, src_data, dst_sel,
      input  gnt, ack, bus, dst_write, busy
   );

   modport slave (
      input  req, lock, src_data, dst_sel,
      output gnt, ack, bus, dst_write, busy
   );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin pick: mask out excluded requesters, rotate so that
// 'start' sits at bit 0, take the first set bit and map it back to an index.
module rr_picker #(
   parameter int  NREQ = 4,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] excl,
   input  logic [IW-1:0]   start,
   output logic            found,
   output logic [IW-1:0]   idx,
   output logic [NREQ-1:0] onehot
);

   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] rotated;
   int              offset;
   int              sum;
   int              j;

   assign eligible = req & ~excl;

   always_comb begin
      rotated = '0;
      found   = 1'b0;
      offset  = 0;
      sum     = 0;
      j       = 0;
      onehot  = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(start) + k;
         if (j >= NREQ) j = j - NREQ;
         rotated[k] = eligible[IW'(j)];
      end
      // Descending scan so the lowest rotated position wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            found  = 1'b1;
            offset = k;
         end
      end
      sum = int'(start) + offset;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IW'(sum);
      if (found) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with lockable grants; 1 cycle req->gnt, one word per ack cycle.
// Requesters hold req until ack; a locked grant is force-released after MAX_BEATS beats.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int W         = 16,
   parameter int NDST      = 4,
   parameter int MAX_BEATS = MAX_BEATS_DEF
) (
   input  logic          clk,
   input  logic          rst,
   bus_arbiter_if.slave  bif
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   state_t            state, state_nxt;
   logic [NREQ-1:0]   gnt_q, gnt_nxt;
   logic [IW-1:0]     g_idx, g_idx_nxt;
   logic [IW-1:0]     last_gnt, last_nxt;
   logic [BW-1:0]     beat_cnt, beat_nxt;
   logic [IW-1:0]     start;
   logic [IW-1:0]     pick_idx;
   logic [NREQ-1:0]   pick_onehot;
   logic [NREQ-1:0]   excl;
   logic              pick_found;
   logic              hold;
   logic [SEL_W-1:0]  sel;

   // A releasing grant counts as the newest last_gnt for this very arbitration.
   assign excl  = (state == XFER) ? gnt_q : '0;
   assign start = IW'(wrap_inc(int'((state == XFER) ? g_idx : last_gnt), NREQ));
   assign hold  = (state == XFER) && bif.req[g_idx] && bif.lock[g_idx] &&
                  (beat_cnt != BW'(MAX_BEATS - 1));

   rr_picker #(.NREQ(NREQ)) u_pick (
      .req    (bif.req),
      .excl   (excl),
      .start  (start),
      .found  (pick_found),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         gnt_q    <= '0;
         g_idx    <= '0;
         last_gnt <= IW'(NREQ - 1);
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gnt_q    <= gnt_nxt;
         g_idx    <= g_idx_nxt;
         last_gnt <= last_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_q;
      g_idx_nxt = g_idx;
      last_nxt  = last_gnt;
      beat_nxt  = beat_cnt;
      if (hold) begin
         beat_nxt = beat_cnt + BW'(1);
      end else begin
         if (state == XFER) last_nxt = g_idx;
         beat_nxt = '0;
         if (pick_found) begin
            state_nxt = XFER;
            gnt_nxt   = pick_onehot;
            g_idx_nxt = pick_idx;
         end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            g_idx_nxt = '0;
         end
      end
   end

   always_comb begin
      bif.bus       = '0;
      bif.dst_write = '0;
      sel           = '0;
      if (state == XFER) begin
         for (int i = 0; i < NREQ; i++) begin
            if (g_idx == IW'(i)) begin
               bif.bus = bif.src_data[i*W +: W];
               sel     = bif.dst_sel[i*SEL_W +: SEL_W];
            end
         end
         // Out-of-range selects decode to no write; the transfer itself still happens.
         for (int d = 0; d < NDST; d++) begin
            bif.dst_write[d] = (int'(sel) == d);
         end
      end
   end

   assign bif.gnt  = gnt_q;
   assign bif.ack  = gnt_q;
   assign bif.busy = (state == XFER);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, hand-written reset-abort sequence,
// and randomized traffic compared against a queue-free behavioural grant model.
module tb_bus_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 16;
   localparam int MAXB = 4;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   bus_arbiter_if #(.NREQ(NREQ), .W(W), .NDST(4)) bif  ();
   bus_arbiter_if #(.NREQ(NREQ), .W(W), .NDST(3)) bif3 ();

   assign bif3.req      = bif.req;
   assign bif3.lock     = bif.lock;
   assign bif3.src_data = bif.src_data;
   assign bif3.dst_sel  = bif.dst_sel;

   bus_arbiter #(.NREQ(NREQ), .W(W), .NDST(4), .MAX_BEATS(MAXB)) dut (
      .clk (clk),
      .rst (rst),
      .bif (bif.slave)
   );

   bus_arbiter #(.NREQ(NREQ), .W(W), .NDST(3), .MAX_BEATS(MAXB)) dut3 (
      .clk (clk),
      .rst (rst),
      .bif (bif3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        do_rst;
      logic [3:0]  req;
      logic [3:0]  lock;
      logic [3:0]  gnt;
      logic [15:0] bus;
      logic [3:0]  dw;
      logic [2:0]  dw3;
   } vec_t;

   vec_t vecs [19];

   // Reference model: granted requester (-1 = none), last released one, beats held.
   int mg;
   int mlast;
   int mrun;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic bitof(input logic [3:0] v, input int i);
      return v[2'(i)];
   endfunction

   task automatic model_reset();
      mg    = -1;
      mlast = NREQ - 1;
      mrun  = 0;
   endtask

   task automatic model_step();
      logic [3:0] r;
      logic [3:0] l;
      int         nxt;
      int         j;
      r = bif.req;
      l = bif.lock;
      if (mg >= 0 && bitof(r, mg) && bitof(l, mg) && mrun < MAXB) begin
         mrun++;
      end else begin
         if (mg >= 0) mlast = mg;
         nxt = -1;
         for (int k = 1; k <= NREQ; k++) begin
            j = (mlast + k) % NREQ;
            if (nxt < 0 && bitof(r, j) && j != mg) nxt = j;
         end
         mg   = nxt;
         mrun = (nxt >= 0) ? 1 : 0;
      end
   endtask

   task automatic model_compare();
      logic [3:0]  eg;
      logic [15:0] eb;
      logic [3:0]  edw;
      logic [2:0]  edw3;
      logic [1:0]  sel;
      eg = '0; eb = '0; edw = '0; edw3 = '0;
      if (mg >= 0) begin
         sel = 2'(bif.dst_sel >> (mg * 2));
         eb  = 16'(bif.src_data >> (mg * W));
         eg  = 4'(1 << mg);
         edw = 4'(1 << sel);
         if (sel < 2'd3) edw3 = 3'(1 << sel);
      end
      chk("rnd_gnt",  bif.gnt,        eg);
      chk("rnd_ack",  bif.ack,        eg);
      chk("rnd_busy", bif.busy,       (mg >= 0));
      chk("rnd_bus",  bif.bus,        eb);
      chk("rnd_dw",   bif.dst_write,  edw);
      chk("rnd_gnt3", bif3.gnt,       eg);
      chk("rnd_dw3",  bif3.dst_write, edw3);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      bif.req  = 4'hF;
      bif.lock = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt",  bif.gnt,       0);
      chk("rst_ack",  bif.ack,       0);
      chk("rst_busy", bif.busy,      0);
      chk("rst_bus",  bif.bus,       0);
      chk("rst_dw",   bif.dst_write, 0);
      bif.req  = '0;
      bif.lock = '0;
      rst      = 1'b1;
      model_reset();
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      rst          = 1'b0;
      bif.req      = '0;
      bif.lock     = '0;
      bif.src_data = {16'h4444, 16'h3333, 16'h2222, 16'hA5A5};
      bif.dst_sel  = {2'd0, 2'd2, 2'd3, 2'd1};
      model_reset();

      //            rst   req      lock     gnt      bus       dw       dw3
      vecs[0]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 16'hA5A5, 4'b0010, 3'b010};
      vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 3'b000};
      vecs[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 16'hA5A5, 4'b0010, 3'b010};
      vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 16'h2222, 4'b1000, 3'b000};
      vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 16'h3333, 4'b0100, 3'b100};
      vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 16'h4444, 4'b0001, 3'b001};
      vecs[6]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 16'hA5A5, 4'b0010, 3'b010};
      vecs[7]  = '{1'b1, 4'b0100, 4'b0100, 4'b0100, 16'h3333, 4'b0100, 3'b100};
      vecs[8]  = '{1'b0, 4'b0101, 4'b0100, 4'b0100, 16'h3333, 4'b0100, 3'b100};
      vecs[9]  = '{1'b0, 4'b0101, 4'b0100, 4'b0100, 16'h3333, 4'b0100, 3'b100};
      vecs[10] = '{1'b0, 4'b0101, 4'b0100, 4'b0100, 16'h3333, 4'b0100, 3'b100};
      vecs[11] = '{1'b0, 4'b0101, 4'b0100, 4'b0001, 16'hA5A5, 4'b0010, 3'b010};
      vecs[12] = '{1'b0, 4'b0101, 4'b0100, 4'b0100, 16'h3333, 4'b0100, 3'b100};
      vecs[13] = '{1'b1, 4'b1010, 4'b0000, 4'b0010, 16'h2222, 4'b1000, 3'b000};
      vecs[14] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 16'h4444, 4'b0001, 3'b001};
      vecs[15] = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 3'b000};
      vecs[16] = '{1'b0, 4'b0001, 4'b0010, 4'b0001, 16'hA5A5, 4'b0010, 3'b010};
      vecs[17] = '{1'b0, 4'b0011, 4'b0010, 4'b0010, 16'h2222, 4'b1000, 3'b000};
      vecs[18] = '{1'b0, 4'b0001, 4'b0010, 4'b0001, 16'hA5A5, 4'b0010, 3'b010};

      for (int i = 0; i < 19; i++) begin
         if (vecs[i].do_rst) do_reset();
         bif.req  = vecs[i].req;
         bif.lock = vecs[i].lock;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_gnt", i),  bif.gnt,        vecs[i].gnt);
         chk($sformatf("vec%0d_ack", i),  bif.ack,        vecs[i].gnt);
         chk($sformatf("vec%0d_busy", i), bif.busy,       (vecs[i].gnt != 4'b0));
         chk($sformatf("vec%0d_bus", i),  bif.bus,        vecs[i].bus);
         chk($sformatf("vec%0d_dw", i),   bif.dst_write,  vecs[i].dw);
         chk($sformatf("vec%0d_dw3", i),  bif3.dst_write, vecs[i].dw3);
         chk($sformatf("vec%0d_gnt3", i), bif3.gnt,       vecs[i].gnt);
      end

      // Reset pulled low between edges while a transfer is on the bus.
      do_reset();
      bif.req = 4'b1111;
      @(posedge clk);
      #1;
      chk("abort_first", bif.gnt, 4'b0001);
      @(posedge clk);
      #1;
      chk("abort_mid", bif.gnt, 4'b0010);
      #3;
      rst = 1'b0;
      #1;
      chk("abort_gnt",  bif.gnt,       0);
      chk("abort_bus",  bif.bus,       0);
      chk("abort_dw",   bif.dst_write, 0);
      chk("abort_busy", bif.busy,      0);
      rst     = 1'b1;
      bif.req = 4'b1000;
      @(posedge clk);
      #1;
      chk("after_abort_gnt", bif.gnt, 4'b1000);
      chk("after_abort_bus", bif.bus, 16'h4444);

      do_reset();
      for (int c = 0; c < 600; c++) begin
         bif.req      = 4'($urandom);
         bif.lock     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         bif.src_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
         bif.dst_sel  = 8'($urandom);
         @(posedge clk);
         model_step();
         #1;
         model_compare();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
